segre_mem_stage: RTL and testbench

Memory stage of the Segre core pipeline, directly downstream of the tag-lookup (TL) stage. It holds the data-cache data array and serves loads from it or from store-buffer data forwarded by TL, including byte/half extraction and sign extension. It applies store-buffer flushes and MMU line fills to the array, and queues every flushed store in a write-through FIFO toward the MMU. Results are registered toward write-back.

---
 rtl/segre_mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_segre_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_stage.sv
// Segre memory stage: data-cache data array, load extraction/sign extension,
// store-buffer flush and MMU fill writes, and the write-through FIFO to the MMU.
package segre_pkg;
   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } memop_data_type_e;
endpackage

module segre_mem_stage
   import segre_pkg::*;
#(
   parameter int WORD_SIZE         = 32,
   parameter int DCACHE_LANE_SIZE  = 128,
   parameter int DCACHE_NUM_LINES  = 4,
   parameter int DCACHE_INDEX_SIZE = $clog2(DCACHE_NUM_LINES),
   parameter int WT_DEPTH          = 2,
   parameter int REG_SIZE          = 5
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [WORD_SIZE-1:0]         alu_res_i,
   input  logic                         rf_we_i,
   input  logic [REG_SIZE-1:0]          rf_waddr_i,
   input  logic [DCACHE_INDEX_SIZE-1:0] addr_index_i,
   input  logic                         memop_rd_i,
   input  logic                         memop_wr_i,
   input  logic                         memop_sign_ext_i,
   input  memop_data_type_e             memop_type_i,
   input  memop_data_type_e             memop_type_flush_i,
   input  logic                         tkbr_i,
   input  logic [WORD_SIZE-1:0]         new_pc_i,
   input  logic                         sb_hit_i,
   input  logic [WORD_SIZE-1:0]         sb_data_load_i,
   input  logic                         sb_flush_i,
   input  logic [WORD_SIZE-1:0]         sb_data_flush_i,
   input  logic [WORD_SIZE-1:0]         sb_addr_i,
   input  logic                         mmu_data_rdy_i,
   input  logic [DCACHE_LANE_SIZE-1:0]  mmu_data_i,
   input  logic [DCACHE_INDEX_SIZE-1:0] mmu_lru_index_i,
   input  logic                         mmu_wr_ack_i,
   output logic                         mmu_wr_req_o,
   output logic [WORD_SIZE-1:0]         mmu_wr_addr_o,
   output logic [WORD_SIZE-1:0]         mmu_wr_data_o,
   output memop_data_type_e             mmu_wr_type_o,
   output logic                         rf_we_o,
   output logic [REG_SIZE-1:0]          rf_waddr_o,
   output logic [WORD_SIZE-1:0]         rf_wdata_o,
   output logic                         tkbr_o,
   output logic [WORD_SIZE-1:0]         new_pc_o,
   output logic                         pipeline_hazard_o
);

   localparam int PTR_W = (WT_DEPTH > 1) ? $clog2(WT_DEPTH) : 1;
   localparam int CNT_W = $clog2(WT_DEPTH + 1);

   typedef struct packed {
      logic [WORD_SIZE-1:0] addr;
      logic [WORD_SIZE-1:0] data;
      memop_data_type_e     typ;
   } wt_entry_t;

   logic [DCACHE_LANE_SIZE-1:0] lines_q [DCACHE_NUM_LINES];
   logic [DCACHE_LANE_SIZE-1:0] lines_d [DCACHE_NUM_LINES];
   logic [DCACHE_LANE_SIZE-1:0] rd_line;
   logic [WORD_SIZE-1:0]        raw_word;
   logic [WORD_SIZE-1:0]        load_val;
   logic [7:0]                  ld_byte;
   logic [15:0]                 ld_half;
   logic                        flush_en;
   logic [3:0]                  flush_be;
   logic [WORD_SIZE-1:0]        flush_data;

   wt_entry_t        fifo_q [WT_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push, pop, full;

   // Loads always see the array as it was before this cycle's writes.
   assign rd_line = lines_q[addr_index_i];

   always_comb begin
      raw_word = sb_hit_i ? sb_data_load_i : rd_line[WORD_SIZE*alu_res_i[3:2] +: WORD_SIZE];
      ld_byte  = raw_word[8*alu_res_i[1:0] +: 8];
      ld_half  = raw_word[16*alu_res_i[1] +: 16];
      case (memop_type_i)
         BYTE:    load_val = {{24{memop_sign_ext_i & ld_byte[7]}}, ld_byte};
         HALF:    load_val = {{16{memop_sign_ext_i & ld_half[15]}}, ld_half};
         default: load_val = raw_word;
      endcase
   end

   assign flush_en = sb_flush_i & memop_wr_i;

   always_comb begin
      case (memop_type_flush_i)
         BYTE: begin
            flush_be   = 4'b0001 << sb_addr_i[1:0];
            flush_data = sb_data_flush_i << {sb_addr_i[1:0], 3'b000};
         end
         HALF: begin
            flush_be   = sb_addr_i[1] ? 4'b1100 : 4'b0011;
            flush_data = sb_addr_i[1] ? {sb_data_flush_i[15:0], 16'h0000}
                                      : {16'h0000, sb_data_flush_i[15:0]};
         end
         default: begin
            flush_be   = 4'b1111;
            flush_data = sb_data_flush_i;
         end
      endcase
   end

   // Fill lands first so that flush bytes to the same line win.
   always_comb begin
      for (int l = 0; l < DCACHE_NUM_LINES; l++) begin
         lines_d[l] = lines_q[l];
         if (mmu_data_rdy_i && mmu_lru_index_i == DCACHE_INDEX_SIZE'(l))
            lines_d[l] = mmu_data_i;
         if (flush_en && addr_index_i == DCACHE_INDEX_SIZE'(l)) begin
            for (int b = 0; b < 4; b++) begin
               if (flush_be[b])
                  lines_d[l][WORD_SIZE*sb_addr_i[3:2] + 8*b +: 8] = flush_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int l = 0; l < DCACHE_NUM_LINES; l++) lines_q[l] <= '0;
      end else begin
         for (int l = 0; l < DCACHE_NUM_LINES; l++) lines_q[l] <= lines_d[l];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
         tkbr_o     <= 1'b0;
         new_pc_o   <= '0;
      end else begin
         rf_we_o    <= rf_we_i;
         rf_waddr_o <= rf_waddr_i;
         rf_wdata_o <= (memop_rd_i | sb_hit_i) ? load_val : alu_res_i;
         tkbr_o     <= tkbr_i;
         new_pc_o   <= new_pc_i;
      end
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(WT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full = (count_q == CNT_W'(WT_DEPTH));
   assign pop  = mmu_wr_ack_i && (count_q != '0);
   // A pop frees the slot being written, so a full FIFO can still take a push.
   assign push = flush_en && (!full || pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < WT_DEPTH; i++) fifo_q[i] <= '{addr: '0, data: '0, typ: WORD};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: sb_addr_i, data: sb_data_flush_i, typ: memop_type_flush_i};
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   assign mmu_wr_req_o      = (count_q != '0);
   assign mmu_wr_addr_o     = fifo_q[rd_ptr_q].addr;
   assign mmu_wr_data_o     = fifo_q[rd_ptr_q].data;
   assign mmu_wr_type_o     = fifo_q[rd_ptr_q].typ;
   assign pipeline_hazard_o = (count_q >= CNT_W'(WT_DEPTH - 1));

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(flush_en && full && !pop));

endmodule

// File: tb/tb_segre_mem_stage.sv
// Bench for segre_mem_stage: directed scenarios plus random traffic against a
// word/byte-level cache model and a queue-based write-through FIFO model.
module tb_segre_mem_stage;
   import segre_pkg::*;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic [31:0]          alu_res_i;
   logic                 rf_we_i;
   logic [4:0]           rf_waddr_i;
   logic [1:0]           addr_index_i;
   logic                 memop_rd_i, memop_wr_i, memop_sign_ext_i;
   memop_data_type_e     memop_type_i, memop_type_flush_i;
   logic                 tkbr_i;
   logic [31:0]          new_pc_i;
   logic                 sb_hit_i;
   logic [31:0]          sb_data_load_i;
   logic                 sb_flush_i;
   logic [31:0]          sb_data_flush_i, sb_addr_i;
   logic                 mmu_data_rdy_i;
   logic [127:0]         mmu_data_i;
   logic [1:0]           mmu_lru_index_i;
   logic                 mmu_wr_ack_i;
   logic                 mmu_wr_req_o;
   logic [31:0]          mmu_wr_addr_o, mmu_wr_data_o;
   memop_data_type_e     mmu_wr_type_o;
   logic                 rf_we_o;
   logic [4:0]           rf_waddr_o;
   logic [31:0]          rf_wdata_o;
   logic                 tkbr_o;
   logic [31:0]          new_pc_o;
   logic                 pipeline_hazard_o;

   segre_mem_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .alu_res_i(alu_res_i), .rf_we_i(rf_we_i),
      .rf_waddr_i(rf_waddr_i), .addr_index_i(addr_index_i), .memop_rd_i(memop_rd_i),
      .memop_wr_i(memop_wr_i), .memop_sign_ext_i(memop_sign_ext_i),
      .memop_type_i(memop_type_i), .memop_type_flush_i(memop_type_flush_i),
      .tkbr_i(tkbr_i), .new_pc_i(new_pc_i), .sb_hit_i(sb_hit_i),
      .sb_data_load_i(sb_data_load_i), .sb_flush_i(sb_flush_i),
      .sb_data_flush_i(sb_data_flush_i), .sb_addr_i(sb_addr_i),
      .mmu_data_rdy_i(mmu_data_rdy_i), .mmu_data_i(mmu_data_i),
      .mmu_lru_index_i(mmu_lru_index_i), .mmu_wr_ack_i(mmu_wr_ack_i),
      .mmu_wr_req_o(mmu_wr_req_o), .mmu_wr_addr_o(mmu_wr_addr_o),
      .mmu_wr_data_o(mmu_wr_data_o), .mmu_wr_type_o(mmu_wr_type_o),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .tkbr_o(tkbr_o), .new_pc_o(new_pc_o), .pipeline_hazard_o(pipeline_hazard_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      d;
      memop_data_type_e t;
   } ent_t;

   int          ncmp = 0;
   int          nerr = 0;
   logic [31:0] mem [4][4];
   ent_t        wq [$];
   logic        e_we, e_tkbr;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata, e_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [31:0] a,
                                            input memop_data_type_e t, input logic sx);
      logic [31:0] v;
      case (t)
         BYTE: begin
            v = (raw >> (8 * a[1:0])) & 32'hFF;
            if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         HALF: begin
            v = (raw >> (16 * a[1])) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         default: v = raw;
      endcase
      return v;
   endfunction

   task automatic model_clear();
      for (int l = 0; l < 4; l++) for (int w = 0; w < 4; w++) mem[l][w] = 32'h0;
      wq.delete();
   endtask

   task automatic idle();
      alu_res_i = 0; rf_we_i = 0; rf_waddr_i = 0; addr_index_i = 0;
      memop_rd_i = 0; memop_wr_i = 0; memop_sign_ext_i = 0;
      memop_type_i = WORD; memop_type_flush_i = WORD;
      tkbr_i = 0; new_pc_i = 0; sb_hit_i = 0; sb_data_load_i = 0;
      sb_flush_i = 0; sb_data_flush_i = 0; sb_addr_i = 0;
      mmu_data_rdy_i = 0; mmu_data_i = '0; mmu_lru_index_i = 0; mmu_wr_ack_i = 0;
   endtask

   task automatic check_outputs();
      chk("rf_we", 32'(rf_we_o), 32'(e_we));
      chk("rf_waddr", 32'(rf_waddr_o), 32'(e_waddr));
      chk("rf_wdata", rf_wdata_o, e_wdata);
      chk("tkbr", 32'(tkbr_o), 32'(e_tkbr));
      chk("new_pc", new_pc_o, e_pc);
      chk("wr_req", 32'(mmu_wr_req_o), 32'(wq.size() != 0));
      chk("hazard", 32'(pipeline_hazard_o), 32'(wq.size() >= 1));
      if (wq.size() != 0) begin
         chk("wr_addr", mmu_wr_addr_o, wq[0].a);
         chk("wr_data", mmu_wr_data_o, wq[0].d);
         chk("wr_type", 32'(mmu_wr_type_o), 32'(wq[0].t));
      end
   endtask

   // Advance one clock: predict from current inputs, apply the model, then compare.
   task automatic step();
      logic [31:0] raw;
      int s, n;
      raw     = sb_hit_i ? sb_data_load_i : mem[addr_index_i][alu_res_i[3:2]];
      e_we    = rf_we_i;
      e_waddr = rf_waddr_i;
      e_tkbr  = tkbr_i;
      e_pc    = new_pc_i;
      e_wdata = (memop_rd_i || sb_hit_i) ? ref_load(raw, alu_res_i, memop_type_i, memop_sign_ext_i)
                                         : alu_res_i;
      if (mmu_wr_ack_i && wq.size() != 0) void'(wq.pop_front());
      if (mmu_data_rdy_i)
         for (int w = 0; w < 4; w++) mem[mmu_lru_index_i][w] = mmu_data_i[32*w +: 32];
      if (sb_flush_i && memop_wr_i) begin
         wq.push_back('{a: sb_addr_i, d: sb_data_flush_i, t: memop_type_flush_i});
         case (memop_type_flush_i)
            BYTE:    begin s = int'(sb_addr_i[1:0]);    n = 1; end
            HALF:    begin s = 2 * int'(sb_addr_i[1]);  n = 2; end
            default: begin s = 0;                       n = 4; end
         endcase
         for (int k = 0; k < n; k++)
            mem[addr_index_i][sb_addr_i[3:2]][8*(s+k) +: 8] = sb_data_flush_i[8*k +: 8];
      end
      @(posedge clk_i);
      #1;
      check_outputs();
   endtask

   task automatic random_inputs();
      alu_res_i = $urandom; rf_we_i = 1'($urandom); rf_waddr_i = 5'($urandom);
      addr_index_i = 2'($urandom);
      memop_rd_i = 1'($urandom); memop_wr_i = 1'($urandom); memop_sign_ext_i = 1'($urandom);
      memop_type_i = memop_data_type_e'($urandom_range(0, 2));
      memop_type_flush_i = memop_data_type_e'($urandom_range(0, 2));
      tkbr_i = 1'($urandom); new_pc_i = $urandom;
      sb_hit_i = ($urandom_range(0, 3) == 0); sb_data_load_i = $urandom;
      sb_flush_i = 1'($urandom); sb_data_flush_i = $urandom; sb_addr_i = $urandom;
      mmu_data_rdy_i = ($urandom_range(0, 3) == 0);
      mmu_data_i = {$urandom, $urandom, $urandom, $urandom};
      mmu_lru_index_i = 2'($urandom); mmu_wr_ack_i = 1'($urandom);
      if (wq.size() >= 2 && !mmu_wr_ack_i) sb_flush_i = 1'b0;
   endtask

   initial begin
      idle();
      model_clear();

      // Reset held with random inputs
      rst_i = 1'b1;
      random_inputs();
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_rf_we", 32'(rf_we_o), 0);
      chk("rst_rf_wdata", rf_wdata_o, 0);
      chk("rst_new_pc", new_pc_o, 0);
      chk("rst_wr_req", 32'(mmu_wr_req_o), 0);
      chk("rst_wr_addr", mmu_wr_addr_o, 0);
      chk("rst_wr_type", 32'(mmu_wr_type_o), 32'(WORD));
      chk("rst_hazard", 32'(pipeline_hazard_o), 0);
      @(negedge clk_i);
      idle();
      rst_i = 1'b0;

      // Fill line 1, then byte/half/word loads from word 1
      mmu_data_rdy_i = 1; mmu_lru_index_i = 1;
      mmu_data_i = 128'h0000_0000_0000_0000_8000_0080_0000_0000;
      step();
      idle(); memop_rd_i = 1; addr_index_i = 1; alu_res_i = 32'h14;
      memop_type_i = BYTE; memop_sign_ext_i = 1; rf_we_i = 1; rf_waddr_i = 5'd7;
      step();
      chk("load_byte_sx", rf_wdata_o, 32'hFFFF_FF80);
      memop_type_i = HALF; memop_sign_ext_i = 0; alu_res_i = 32'h16;
      step();
      chk("load_half_zx", rf_wdata_o, 32'h0000_8000);
      memop_type_i = WORD; alu_res_i = 32'h14;
      step();
      chk("load_word", rf_wdata_o, 32'h8000_0080);

      // Half flush into line 2, then read it back while draining the FIFO
      idle(); sb_flush_i = 1; memop_wr_i = 1; memop_type_flush_i = HALF;
      sb_addr_i = 32'h22; sb_data_flush_i = 32'hBEEF; addr_index_i = 2;
      step();
      chk("wt_req", 32'(mmu_wr_req_o), 1);
      chk("wt_addr", mmu_wr_addr_o, 32'h22);
      chk("wt_data", mmu_wr_data_o, 32'h0000_BEEF);
      chk("wt_type", 32'(mmu_wr_type_o), 32'(HALF));
      idle(); memop_rd_i = 1; addr_index_i = 2; alu_res_i = 32'h20; mmu_wr_ack_i = 1;
      step();
      chk("flush_readback", rf_wdata_o, 32'hBEEF_0000);

      // Store-buffer forwarded load ignores the array
      idle(); sb_hit_i = 1; memop_rd_i = 1; sb_data_load_i = 32'h1234_5678;
      memop_type_i = BYTE; memop_sign_ext_i = 1; alu_res_i = 32'h3; addr_index_i = 1;
      step();
      chk("sb_fwd_byte", rf_wdata_o, 32'h0000_0012);

      // FIFO fill, push+pop at full, then drain in order
      idle(); sb_flush_i = 1; memop_wr_i = 1; memop_type_flush_i = WORD;
      sb_addr_i = 32'h100; sb_data_flush_i = 32'hA1A1_A1A1;
      step();
      chk("haz_one", 32'(pipeline_hazard_o), 1);
      sb_addr_i = 32'h104; sb_data_flush_i = 32'hB2B2_B2B2;
      step();
      sb_addr_i = 32'h108; sb_data_flush_i = 32'hC3C3_C3C3; mmu_wr_ack_i = 1;
      step();
      chk("full_pushpop_head", mmu_wr_addr_o, 32'h104);
      idle(); mmu_wr_ack_i = 1;
      step();
      chk("drain_head", mmu_wr_addr_o, 32'h108);
      step();
      chk("drain_haz", 32'(pipeline_hazard_o), 0);
      step();

      // Same-cycle fill of line 0 and byte flush into it
      idle(); mmu_data_rdy_i = 1; mmu_lru_index_i = 0; mmu_data_i = '1;
      sb_flush_i = 1; memop_wr_i = 1; memop_type_flush_i = BYTE;
      sb_addr_i = 32'h1; sb_data_flush_i = 32'h0; addr_index_i = 0;
      step();
      idle(); memop_rd_i = 1; alu_res_i = 32'h0; addr_index_i = 0; mmu_wr_ack_i = 1;
      step();
      chk("fill_flush_merge", rf_wdata_o, 32'hFFFF_00FF);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         random_inputs();
         step();
      end

      // Asynchronous reset mid-transfer discards FIFO contents
      idle(); sb_flush_i = 1; memop_wr_i = 1; sb_addr_i = 32'h44; sb_data_flush_i = 32'h55;
      step();
      step();
      idle();
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_req", 32'(mmu_wr_req_o), 0);
      chk("async_rst_haz", 32'(pipeline_hazard_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      model_clear();
      e_we = 0; e_waddr = 0; e_wdata = 0; e_tkbr = 0; e_pc = 0;
      memop_rd_i = 1; addr_index_i = 2; alu_res_i = 32'h20;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
